// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit with HI/LO registers; divider present only when MDU_DIV_EN is defined
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             kill_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_DIV_EN
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SIGN, S_DONE} state_t;

  state_t               state;
  // Upper half: product accumulator / partial remainder; lower half: multiplier / quotient.
  logic [2*WIDTH-1:0]   prod;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]     mcand;
  logic [CW-1:0]        cnt;
  logic                 neg_lo;

  logic                 op_mul;
  logic                 op_div;
  logic                 signed_op;
  logic                 rs_neg;
  logic                 rt_neg;
  logic [WIDTH-1:0]     rs_mag;
  logic [WIDTH-1:0]     rt_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   step_next;
  logic [2*WIDTH-1:0]   prod_neg;
  logic [WIDTH-1:0]     res_hi;
  logic [WIDTH-1:0]     res_lo;
  logic                 res_err;

`ifdef MDU_DIV_EN
  logic                 is_div;
  logic                 div_zero;
  logic                 neg_hi;
  logic [WIDTH:0]       div_trial;
  logic [WIDTH-1:0]     div_rem;
  logic [WIDTH-1:0]     div_quo;
`endif

  assign ready_o = (state == S_IDLE);
  assign busy_o  = (state != S_IDLE);

  // Opcode decode and operand magnitude conversion at accept time
  always_comb begin
    op_mul    = (op_i == OP_MULT) || (op_i == OP_MULTU);
`ifdef MDU_DIV_EN
    op_div    = (op_i == OP_DIV) || (op_i == OP_DIVU);
    signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
`else
    op_div    = 1'b0;
    signed_op = (op_i == OP_MULT);
`endif
    rs_neg    = signed_op && rs_data_i[WIDTH-1];
    rt_neg    = signed_op && rt_data_i[WIDTH-1];
    rs_mag    = rs_neg ? -rs_data_i : rs_data_i;
    rt_mag    = rt_neg ? -rt_data_i : rt_data_i;
  end

  // One iteration: shift-add multiply step, or restoring divide step
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    step_next = {mul_sum, prod[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    div_trial = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]} - {1'b0, mcand};
    if (is_div) begin
      if (div_trial[WIDTH]) begin
        step_next = {prod[2*WIDTH-2:0], 1'b0};
      end else begin
        step_next = {div_trial[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
      end
    end
`endif
  end

  // Sign restoration and special-case results, consumed on the SIGN->DONE edge
  always_comb begin
    prod_neg         = -prod;
    {res_hi, res_lo} = neg_lo ? prod_neg : prod;
    res_err          = 1'b0;
`ifdef MDU_DIV_EN
    div_rem = prod[2*WIDTH-1:WIDTH];
    div_quo = prod[WIDTH-1:0];
    if (is_div) begin
      // A zero divisor leaves the dividend magnitude in the remainder half,
      // so HI still comes out as the original dividend after sign restore.
      res_hi  = neg_hi ? -div_rem : div_rem;
      res_lo  = div_zero ? '1 : (neg_lo ? -div_quo : div_quo);
      res_err = div_zero;
    end
`endif
  end

  // Control FSM, iteration datapath and HI/LO result registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state  <= S_IDLE;
      prod   <= '0;
      mcand  <= '0;
      cnt    <= '0;
      neg_lo <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
`ifdef MDU_DIV_EN
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      neg_hi   <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_i && !kill_i) begin
            if (op_mul || op_div) begin
              state  <= S_RUN;
              cnt    <= '0;
              mcand  <= op_div ? rt_mag : rs_mag;
              prod   <= {{WIDTH{1'b0}}, (op_div ? rs_mag : rt_mag)};
              neg_lo <= rs_neg ^ rt_neg;
`ifdef MDU_DIV_EN
              is_div   <= op_div;
              div_zero <= (rt_data_i == '0);
              neg_hi   <= rs_neg;
`endif
            end else if (op_i == OP_MTHI) begin
              hi_o <= rs_data_i;
            end else if (op_i == OP_MTLO) begin
              lo_o <= rs_data_i;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (kill_i) begin
            state <= S_IDLE;
          end else begin
            prod <= step_next;
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              state <= S_SIGN;
            end
          end
        end
        S_SIGN: begin
          if (kill_i) begin
            state <= S_IDLE;
          end else begin
            state  <= S_DONE;
            hi_o   <= res_hi;
            lo_o   <= res_lo;
            done_o <= 1'b1;
            err_o  <= res_err;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit with randomized ops and an arithmetic reference model
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] rs = '0;
  logic [W-1:0] rt = '0;
  logic         kill = 1'b0;
  logic         ready_o;
  logic         busy_o;
  logic         done_o;
  logic         err_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  typedef struct {
    bit           done;
    bit           err;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .valid_i   (valid),
    .op_i      (op),
    .rs_data_i (rs),
    .rt_data_i (rt),
    .kill_i    (kill),
    .ready_o   (ready_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done/err pulse must match the oldest expected response
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (done_o || err_o)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got done=%0b err=%0b expected no pulse (cycle %0d)", done_o, err_o, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("done_o", 64'(done_o), 64'(e.done));
        chk("err_o", 64'(err_o), 64'(e.err));
        chk("hi_o", 64'(hi_o), 64'(e.hi));
        chk("lo_o", 64'(lo_o), 64'(e.lo));
        chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Reference model: plain wide arithmetic on the architectural meaning of each opcode
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t              e;
    logic [2*W-1:0]    p;
    logic signed [63:0] sa, sb, q, r;
    bit                div_op;
    int                n;
    n = 0;
    while (!ready_o && n < W + 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_o) chk("ready_timeout", 64'(ready_o), 64'd1);
    valid = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
`ifdef MDU_DIV_EN
    div_op = (o == 3'd2) || (o == 3'd3);
`else
    div_op = 1'b0;
`endif
    e.done = 1'b1;
    e.err  = 1'b0;
    e.cyc  = cyc + W + 2;
    if (o == 3'd0 || o == 3'd1) begin
      if (o == 3'd0) p = 64'($signed(a)) * 64'($signed(b));
      else           p = {32'b0, a} * {32'b0, b};
      m_hi = p[2*W-1:W];
      m_lo = p[W-1:0];
      e.hi = m_hi; e.lo = m_lo;
      exp_q.push_back(e);
    end else if (div_op) begin
      if (b == '0) begin
        m_hi  = a;
        m_lo  = '1;
        e.err = 1'b1;
      end else begin
        if (o == 3'd2) begin
          sa = 64'($signed(a));
          sb = 64'($signed(b));
        end else begin
          sa = {32'b0, a};
          sb = {32'b0, b};
        end
        q = sa / sb;
        r = sa % sb;
        m_lo = q[W-1:0];
        m_hi = r[W-1:0];
      end
      e.hi = m_hi; e.lo = m_lo;
      exp_q.push_back(e);
    end else if (o == 3'd4) begin
      m_hi = a;
    end else if (o == 3'd5) begin
      m_lo = a;
    end else begin
      e.done = 1'b0;
      e.err  = 1'b1;
      e.cyc  = cyc + 1;
      e.hi = m_hi; e.lo = m_lo;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while ((!ready_o || exp_q.size() != 0) && n < 4 * W) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [W-1:0] sv_hi, sv_lo;
    exp_t         dropped;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_hi", 64'(hi_o), 64'd0);
    chk("rst_lo", 64'(lo_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd0, -32'sd3, 32'd7);
`ifdef MDU_DIV_EN
    issue(3'd2, -32'sd7, 32'd2);
    issue(3'd3, 32'd100, 32'd0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd2, -32'sd9, 32'd0);
    issue(3'd3, 32'd7, 32'd9);
    issue(3'd2, 32'd7, -32'sd2);
`else
    wait_idle();
    sv_hi = hi_o;
    sv_lo = lo_o;
    issue(3'd2, 32'd55, 32'd5);
    chk("nodiv_busy", 64'(busy_o), 64'd0);
    chk("nodiv_ready", 64'(ready_o), 64'd1);
    @(posedge clk); #1;
    chk("nodiv_hi", 64'(hi_o), 64'(sv_hi));
    chk("nodiv_lo", 64'(lo_o), 64'(sv_lo));
`endif
    wait_idle();

    issue(3'd4, 32'h1234, 32'd0);
    chk("mthi_hi", 64'(hi_o), 64'h1234);
    chk("mthi_busy", 64'(busy_o), 64'd0);
    issue(3'd0, 32'd5, 32'd6);
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1;
      op    = 3'd5;
      rs    = 32'hDEAD;
      @(posedge clk); #1;
      chk("busy_ready", 64'(ready_o), 64'd0);
      chk("busy_hi_held", 64'(hi_o), 64'h1234);
    end
    valid = 1'b0;
    wait_idle();
    chk("after_busy_lo", 64'(lo_o), 64'd30);

    issue(3'd6, 32'd1, 32'd2);
    issue(3'd7, 32'd3, 32'd4);
    wait_idle();

    sv_hi = m_hi;
    valid = 1'b1; kill = 1'b1; op = 3'd4; rs = 32'hBEEF;
    @(posedge clk); #1;
    valid = 1'b0; kill = 1'b0;
    chk("idle_kill_hi", 64'(hi_o), 64'(sv_hi));

    sv_hi = m_hi;
    sv_lo = m_lo;
    issue(3'd0, 32'h0001_2345, 32'h0006_789A);
    dropped = exp_q.pop_back();
    m_hi = sv_hi;
    m_lo = sv_lo;
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_ready", 64'(ready_o), 64'd1);
    chk("kill_busy", 64'(busy_o), 64'd0);
    chk("kill_hi", 64'(hi_o), 64'(sv_hi));
    chk("kill_lo", 64'(lo_o), 64'(sv_lo));
    repeat (W + 4) @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), rnd_val(), rnd_val());
    end
    wait_idle();

`ifdef MDU_DIV_EN
    issue(3'd2, 32'd1000, 32'd7);
`else
    issue(3'd0, 32'd1000, 32'd7);
`endif
    dropped = exp_q.pop_back();
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    chk("midrst_hi", 64'(hi_o), 64'd0);
    chk("midrst_lo", 64'(lo_o), 64'd0);
    chk("midrst_ready", 64'(ready_o), 64'd1);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    repeat (W + 4) @(posedge clk);
    #1;
    issue(3'd1, 32'h0000_FFFF, 32'h0001_0001);
    wait_idle();

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/HI/LO width (legal 8..64, even).
REQ-002 SHALL have ports: clk_i  in  1  clock, all logic on rising edge.
REQ-003 SHALL have ports: rst_n_i  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: valid_i  in  1  command strobe; op_i  in  3  opcode; rs_data_i  in  WIDTH  dividend/multiplicand/MT data; rt_data_i  in  WIDTH  divisor/multiplier.
REQ-005 SHALL have ports: kill_i  in  1  abort in-flight op; ready_o  out  1  idle, command accepted; busy_o  out  1  op in flight; done_o  out  1  one-cycle completion pulse; err_o  out  1  one-cycle error pulse; hi_o  out  WIDTH  HI register; lo_o  out  WIDTH  LO register.

Function
REQ-006 SHALL decode op_i: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
REQ-007 SHALL accept a command only on a cycle with valid_i=1 and ready_o=1; valid_i while ready_o=0 SHALL be ignored.
REQ-008 SHALL implement FSM states IDLE, RUN, SIGN, DONE; IDLE->RUN on accepted mul/div; RUN->SIGN after exactly WIDTH iterations; SIGN->DONE; DONE->IDLE unconditionally.
REQ-009 SHALL hold ready_o=1 only in IDLE and busy_o=1 in RUN, SIGN, DONE.
REQ-010 SHALL latch operands at accept; signed ops SHALL convert to magnitudes at accept and restore sign in SIGN.
REQ-011 SHALL perform radix-2 shift-add multiply, one bit per RUN cycle, producing 2*WIDTH-bit product, HI=upper half, LO=lower half.
REQ-012 SHALL perform restoring divide, one quotient bit per RUN cycle; LO=quotient truncated toward zero, HI=remainder with sign of dividend.
REQ-013 SHALL on divisor zero write HI=dividend, LO=all ones, and pulse err_o with done_o.
REQ-014 SHALL on DIV of most-negative value by -1 write LO=most-negative value, HI=0, no err_o.
REQ-015 SHALL update hi_o/lo_o on entry to DONE and assert done_o for exactly that DONE cycle; latency accept->done_o = WIDTH+2 cycles.
REQ-016 SHALL execute MTHI/MTLO in one cycle from IDLE: HI (resp. LO) = rs_data_i on the next edge, no busy_o, no done_o.
REQ-017 SHALL accept reserved opcodes with no state change, and pulse err_o in the following cycle.
REQ-018 SHALL, on kill_i=1 in RUN or SIGN, return to IDLE next cycle with HI/LO unchanged and no done_o; kill_i in DONE SHALL not suppress the result.
REQ-019 SHALL give kill_i priority over valid_i in IDLE: command dropped, no effect.
REQ-020 SHALL keep hi_o/lo_o stable except on DONE entry, MTHI/MTLO, or reset.

Reset
REQ-021 SHALL, when rst_n_i=0 at a rising edge, enter IDLE and clear hi_o, lo_o, done_o, err_o, busy_o to 0, ready_o=1 after the edge.
REQ-022 SHALL abandon any in-flight op on reset without updating HI/LO.

Configuration
REQ-023 SHALL use macro MDU_DIV_EN: defined -> DIV/DIVU per REQ-012..014.
REQ-024 SHALL, with MDU_DIV_EN undefined, treat DIV/DIVU as reserved (REQ-017), omitting all divider logic.

Verification
REQ-025 WIDTH=32, MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done_o at cycle 34, HI=0xFFFFFFFE, LO=0x00000001.
REQ-026 MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-027 DIVU 100 / 0 -> HI=100, LO=0xFFFFFFFF, err_o and done_o same cycle; DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
REQ-028 MTHI 0x1234 then MULT issued while busy -> second valid_i ignored, ready_o=0 throughout, HI=0x1234 until first op done.
REQ-029 kill_i at RUN cycle 10 of MULT -> IDLE next cycle, no done_o, HI/LO unchanged; rst_n_i=0 mid-DIV -> HI=LO=0, ready_o=1.
REQ-030 MDU_DIV_EN undefined, DIV issued -> err_o one cycle later, no busy_o, HI/LO unchanged.
